// File: rtl/mp3_spi_arbiter.sv
// Arbitrates SCI command writes and SDI data words onto the shared VS10xx serial link.
// Frames are shifted MSB-first on a divided SCK, gated on DREQ, with a chip-select gap after each frame.
module mp3_spi_arbiter #(
    parameter int SCK_DIV    = 25,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_DREQ,
    input  logic        i_cmd_req,
    input  logic [7:0]  i_cmd_addr,
    input  logic [15:0] i_cmd_data,
    output logic        o_cmd_ack,
    input  logic        i_data_req,
    input  logic [15:0] i_data,
    output logic        o_data_ack,
    output logic        o_XCS,
    output logic        o_XDCS,
    output logic        o_SCK,
    output logic        o_SI,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [31:0]        shift_q, shift_d;
    logic               is_cmd_q, is_cmd_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               sck_q, sck_d;
    logic               si_q, si_d;
    logic               xcs_q, xcs_d;
    logic               xdcs_q, xdcs_d;
    logic               cmd_ack_q, cmd_ack_d;
    logic               data_ack_q, data_ack_d;
    logic               last_cmd_q, last_cmd_d;

    logic               grant_cmd;
    logic [31:0]        frame;
    logic [4:0]         last_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            is_cmd_q   <= 1'b0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sck_q      <= 1'b0;
            si_q       <= 1'b0;
            xcs_q      <= 1'b1;
            xdcs_q     <= 1'b1;
            cmd_ack_q  <= 1'b0;
            data_ack_q <= 1'b0;
            last_cmd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            is_cmd_q   <= is_cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sck_q      <= sck_d;
            si_q       <= si_d;
            xcs_q      <= xcs_d;
            xdcs_q     <= xdcs_d;
            cmd_ack_q  <= cmd_ack_d;
            data_ack_q <= data_ack_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        is_cmd_d   = is_cmd_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sck_d      = sck_q;
        si_d       = si_q;
        xcs_d      = xcs_q;
        xdcs_d     = xdcs_q;
        cmd_ack_d  = 1'b0;
        data_ack_d = 1'b0;
        last_cmd_d = last_cmd_q;

        // On contention the port that did not win last time gets the link.
        grant_cmd = i_cmd_req && (!i_data_req || !last_cmd_q);
        frame     = grant_cmd ? {8'h02, i_cmd_addr, i_cmd_data} : {i_data, 16'h0000};
        last_bit  = is_cmd_q ? 5'd31 : 5'd15;

        unique case (state_q)
            IDLE: begin
                if (i_DREQ && (i_cmd_req || i_data_req)) begin
                    state_d    = SHIFT;
                    shift_d    = frame;
                    si_d       = frame[31];
                    sck_d      = 1'b0;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    is_cmd_d   = grant_cmd;
                    last_cmd_d = grant_cmd;
                    xcs_d      = !grant_cmd;
                    xdcs_d     = grant_cmd;
                    cmd_ack_d  = grant_cmd;
                    data_ack_d = !grant_cmd;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_cnt_q == last_bit) begin
                            bit_cnt_d = '0;
                            si_d      = 1'b0;
                            xcs_d     = 1'b1;
                            xdcs_d    = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = GAP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shift_d   = shift_q << 1;
                            si_d      = shift_q[30];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_cmd_ack  = cmd_ack_q;
    assign o_data_ack = data_ack_q;
    assign o_XCS      = xcs_q;
    assign o_XDCS     = xdcs_q;
    assign o_SCK      = sck_q;
    assign o_SI       = si_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mp3_spi_arbiter.sv
// Scoreboard bench for mp3_spi_arbiter: drivers queue expected frames, a pin-level
// monitor reassembles each frame from SCK rising edges and compares.
module tb_mp3_spi_arbiter;

    localparam int SCK_DIV = 2;
    localparam int GAP     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_DREQ = 1'b0;
    logic        i_cmd_req = 1'b0;
    logic [7:0]  i_cmd_addr = '0;
    logic [15:0] i_cmd_data = '0;
    logic        i_data_req = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_cmd_ack, o_data_ack, o_XCS, o_XDCS, o_SCK, o_SI, o_busy;

    mp3_spi_arbiter #(.SCK_DIV(SCK_DIV), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_DREQ     (i_DREQ),
        .i_cmd_req  (i_cmd_req),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_data (i_cmd_data),
        .o_cmd_ack  (o_cmd_ack),
        .i_data_req (i_data_req),
        .i_data     (i_data),
        .o_data_ack (o_data_ack),
        .o_XCS      (o_XCS),
        .o_XDCS     (o_XDCS),
        .o_SCK      (o_SCK),
        .o_SI       (o_SI),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_cmd;
        logic [31:0] bits;
    } frame_t;

    frame_t      exp_q[$];
    logic [7:0]  cmd_addr_list[$];
    logic [15:0] cmd_data_list[$];
    logic [15:0] data_list[$];

    task automatic push_cmd(input logic [7:0] a, input logic [15:0] d);
        frame_t f;
        f.is_cmd = 1'b1;
        f.bits   = {8'h02, a, d};
        exp_q.push_back(f);
        cmd_addr_list.push_back(a);
        cmd_data_list.push_back(d);
    endtask

    task automatic push_data(input logic [15:0] w);
        frame_t f;
        f.is_cmd = 1'b0;
        f.bits   = {16'h0000, w};
        exp_q.push_back(f);
        data_list.push_back(w);
    endtask

    // ---------------- monitor ----------------
    logic        prev_xcs = 1'b1, prev_xdcs = 1'b1, prev_sck = 1'b0;
    bit          in_frame = 1'b0, have_prev = 1'b0, cur_cmd = 1'b0;
    logic [31:0] mon_bits = '0;
    int          mon_nbits = 0, low_cnt = 0, high_cnt = 0, last_gap = 0;
    frame_t      mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            have_prev = 1'b0;
        end else begin
            if ((!o_XCS || !o_XDCS) && !(!prev_xcs || !prev_xdcs)) begin
                check("sck_low_at_cs_fall", o_SCK, 1'b0);
                check("cs_one_low", o_XCS ^ o_XDCS, 1'b1);
                if (have_prev) last_gap = high_cnt;
                in_frame  = 1'b1;
                cur_cmd   = !o_XCS;
                mon_bits  = '0;
                mon_nbits = 0;
                low_cnt   = 0;
            end
            if (in_frame && (!o_XCS || !o_XDCS)) begin
                low_cnt++;
                if (o_SCK && !prev_sck) begin
                    mon_bits = {mon_bits[30:0], o_SI};
                    mon_nbits++;
                end
            end
            if (in_frame && o_XCS && o_XDCS && (!prev_xcs || !prev_xdcs)) begin
                check("sck_low_at_cs_rise", o_SCK, 1'b0);
                check("frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("frame_port", cur_cmd, mon_e.is_cmd);
                    check("frame_bits", mon_bits, mon_e.bits);
                    check("frame_len", mon_nbits, mon_e.is_cmd ? 32 : 16);
                    check("cs_low_clks", low_cnt, (mon_e.is_cmd ? 32 : 16) * 2 * SCK_DIV);
                end
                in_frame  = 1'b0;
                have_prev = 1'b1;
                high_cnt  = 0;
            end
            if (o_XCS && o_XDCS) high_cnt++;
        end
        prev_xcs  = o_XCS;
        prev_xdcs = o_XDCS;
        prev_sck  = o_SCK;
    end

    // ---------------- drivers ----------------
    task automatic wait_ack(input bit is_cmd, input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(is_cmd ? o_cmd_ack : o_data_ack) && n < 3000);
        check(name, is_cmd ? o_cmd_ack : o_data_ack, 1'b1);
    endtask

    task automatic run_cmd_port();
        while (cmd_addr_list.size() != 0) begin
            i_cmd_addr = cmd_addr_list[0];
            i_cmd_data = cmd_data_list[0];
            i_cmd_req  = 1'b1;
            wait_ack(1'b1, "cmd_ack_seen");
            void'(cmd_addr_list.pop_front());
            void'(cmd_data_list.pop_front());
            if (cmd_addr_list.size() != 0) begin
                i_cmd_addr = cmd_addr_list[0];
                i_cmd_data = cmd_data_list[0];
            end else begin
                i_cmd_req = 1'b0;
            end
            @(posedge clk);
            #1;
            check("cmd_ack_single_pulse", o_cmd_ack, 1'b0);
        end
    endtask

    task automatic run_data_port();
        while (data_list.size() != 0) begin
            i_data     = data_list[0];
            i_data_req = 1'b1;
            wait_ack(1'b0, "data_ack_seen");
            void'(data_list.pop_front());
            if (data_list.size() != 0) i_data = data_list[0];
            else i_data_req = 1'b0;
            @(posedge clk);
            #1;
            check("data_ack_single_pulse", o_data_ack, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (o_busy && n < 3000);
        check("idle_reached", o_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int n;

        i_DREQ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_XCS, o_XDCS, o_SCK, o_SI, o_cmd_ack, o_data_ack, o_busy}, 7'b1100000);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single command
        push_cmd(8'h0B, 16'h2020);
        run_cmd_port();
        wait_idle();

        // single data word
        push_data(16'hA55A);
        run_data_port();
        wait_idle();

        // contention: strict alternation starting with command
        push_cmd(8'h03, 16'h1234);
        push_data(16'hBEEF);
        push_cmd(8'h04, 16'h5678);
        push_data(16'hCAFE);
        fork
            run_cmd_port();
            run_data_port();
        join
        wait_idle();

        // DREQ gating
        i_DREQ     = 1'b0;
        push_cmd(8'h0A, 16'h8001);
        void'(cmd_addr_list.pop_front());
        void'(cmd_data_list.pop_front());
        i_cmd_addr = 8'h0A;
        i_cmd_data = 16'h8001;
        i_cmd_req  = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (o_cmd_ack || !o_XCS || !o_XDCS) bad++;
        end
        check("dreq_low_holds", bad, 0);
        i_DREQ = 1'b1;
        @(posedge clk);
        #1;
        check("dreq_first_edge_capture", {o_cmd_ack, o_XCS}, 2'b10);
        i_cmd_req = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        i_DREQ = 1'b0;
        push_data(16'h0F0F);
        void'(data_list.pop_front());
        i_data     = 16'h0F0F;
        i_data_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_XCS && n < 3000);
        check("frame_completes_without_dreq", o_XCS, 1'b1);
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (o_data_ack || !o_XDCS) bad++;
        end
        check("dreq_gates_next_capture", bad, 0);
        i_DREQ = 1'b1;
        wait_ack(1'b0, "data_ack_after_dreq");
        i_data_req = 1'b0;
        wait_idle();

        // reset in the middle of a data frame, request held throughout
        push_data(16'h1234);
        void'(data_list.pop_front());
        i_data     = 16'h1234;
        i_data_req = 1'b1;
        wait_ack(1'b0, "data_ack_before_reset");
        repeat (23) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_midframe", {o_XDCS, o_XCS, o_SCK, o_SI, o_data_ack, o_busy}, 6'b110000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("resend_first_edge", {o_data_ack, o_XDCS}, 2'b10);
        i_data_req = 1'b0;
        wait_idle();

        // back-to-back data frames
        push_data(16'h0001);
        push_data(16'h8000);
        run_data_port();
        wait_idle();
        check("b2b_cs_high_clks", last_gap, GAP + 1);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mp3_spi_arbiter.md
Name: mp3_spi_arbiter

Overview:
Shares the single serial link to the VS10xx decoder between two requesters: an SCI command port (volume, effect and mode register writes) and an SDI data port (the 16-bit audio word stream from block RAM). It grants one transaction at a time and gates each start on DREQ. It serialises the frame MSB-first with a divided SCK, drives XCS/XDCS, and enforces a chip-select gap between frames. It sits between the player sequencer and the decoder pins, replacing per-state inline shifting.

Parameters:
SCK_DIV, 25, clk cycles per SCK half-period (>=1)
GAP_CYCLES, 4, clk cycles both chip-selects stay high after each frame (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
i_DREQ  in  1  decoder data request; high = decoder can accept a frame
i_cmd_req  in  1  SCI write request; held high until o_cmd_ack
i_cmd_addr  in  8  SCI register address
i_cmd_data  in  16  SCI register value
o_cmd_ack  out  1  one-cycle pulse; command captured
i_data_req  in  1  SDI word request; held high until o_data_ack
i_data  in  16  SDI word
o_data_ack  out  1  one-cycle pulse; word captured
o_XCS  out  1  SCI chip select, active low
o_XDCS  out  1  SDI chip select, active low
o_SCK  out  1  serial clock; decoder samples SI on rising edge
o_SI  out  1  serial data
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: o_XCS=1, o_XDCS=1, o_SCK=0, o_SI=0, o_cmd_ack=0, o_data_ack=0, o_busy=0; state=IDLE; last_grant=DATA, so the first contested grant goes to the command port.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE, capture edge: capture occurs on an edge where i_DREQ=1 and at least one request is high.
  - Command frame: 32 bits = {8'h02, i_cmd_addr, i_cmd_data}.
  - Data frame: 16 bits = i_data.
  - On that edge: load the shift register and frame length; set o_SI = frame MSB, o_SCK=0; drive the selected CS low and keep the other high.
  - Also on that edge: pulse the matching ack high for exactly the next cycle, update last_grant, go to SHIFT.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_grant wins (strict alternation).
  - i_DREQ=0: no capture and no ack; requests stay pending.
- SHIFT:
  - A divider counts 0..SCK_DIV-1, then toggles o_SCK and resets.
  - On a 0->1 toggle, SI is held.
  - On a 1->0 toggle, the bit counter increments:
    - Bit counter was N-1: CS goes high, o_SCK stays 0, go to GAP.
    - Otherwise: o_SI <= next bit.
  - CS-low duration = N*2*SCK_DIV clk, which is 32*2*SCK_DIV for command frames and 16*2*SCK_DIV for data frames.
  - SCK is low at both CS edges.
- DREQ mid-frame: i_DREQ is ignored once SHIFT is entered and the frame always completes (decoder FIFO guarantees space for one word/command). DREQ is only checked again at the next IDLE capture.
- GAP: both CS high and SCK low for exactly GAP_CYCLES clk, then IDLE. The earliest next CS-low is GAP_CYCLES+1 clk after CS-high (one IDLE capture edge).
- Request inputs and payloads are sampled only at the capture edge. Later payload changes do not affect the frame in flight.
- A request that stays high after its ack is treated as a new request at the next IDLE.
- Reset mid-frame: on the next edge all outputs return to reset values and the frame is abandoned without an ack. A request still held is re-sent from its MSB after reset releases.

Test Plan:
- SCK_DIV=2, GAP=2, DREQ=1, command addr 8'h0B data 16'h2020 → o_cmd_ack one pulse; XCS low 128 clk; XDCS stays 1; 32 bits sampled on SCK rise = 32'h020B2020; then 2 clk gap; busy drops.
- Data word 16'hA55A only → XDCS low 64 clk; 16 rising edges read 16'hA55A; XCS stays 1; o_data_ack one pulse.
- Both requests held continuously, re-presented after each ack → grant order cmd, data, cmd, data; no two consecutive frames from the same port.
- DREQ=0 with requests pending for 50 clk → no CS activity, no ack. Raise DREQ → capture on first edge. Drop DREQ mid-frame → frame completes intact, next capture waits for DREQ=1.
- Assert rst_n=0 for one cycle at bit 10 of a data frame → next edge XDCS=1, SCK=0, SI=0, no ack. Held request resent from bit 15 after release.
- Back-to-back data frames → CS-high interval between frames is exactly GAP_CYCLES+1 clk; SCK low at every CS transition.
